// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider and multiplier family:
// FSM state encodings and the default operand width.
package seq_div_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : seq_div_pkg

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and record the quotient bit.
module div_step
  import seq_div_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N:0]   i_r,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_d,
  output logic [N:0]   o_r,
  output logic [N-1:0] o_q
);

  logic [N:0] w_t;
  logic       w_unused_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // shifted out and never contributes to the trial value.
  assign w_t          = {i_r[N-1:0], i_q[N-1]};
  assign w_unused_msb = i_r[N];

  // Trial subtraction: keep the difference only when the divisor fits.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    o_r = w_t;
    o_q = {i_q[N-2:0], 1'b0};
    if (w_t >= {1'b0, i_d}) begin
      o_r    = w_t - {1'b0, i_d};
      o_q[0] = 1'b1;
    end
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, N clocks per
// division, results held in output registers until the next completion.
// A zero divisor skips the iteration and reports div_by_zero with done.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_state_nxt;

  logic [N:0]     r_r;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_d;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quotient;
  logic [N-1:0]   r_remainder;
  logic           r_dbz;

  logic [N:0]     w_r_nxt;
  logic [N-1:0]   w_q_nxt;
  logic           w_accept;
  logic           w_last;
  logic           w_div_zero;

  // A start is taken only outside RUN and only when no abort is requested.
  assign w_accept   = start && !stop && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_div_zero = (divisor == '0);

  div_step #(.N(N)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; stop overrides everything, including a new start.
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) w_state_nxt = w_div_zero ? ST_DONE : ST_RUN;
          else          w_state_nxt = ST_IDLE;
        end
        ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  // Datapath: operand capture on accept, one step per RUN cycle, result load
  // on the final step. An abort leaves everything as it is.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every datapath register is reset so outputs are defined
    // immediately when rst rises, not just after the next edge.
    if (rst) begin
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (!stop) begin
      if (w_accept) begin
        r_q   <= dividend;
        r_r   <= '0;
        r_d   <= divisor;
        r_cnt <= '0;
        r_dbz <= w_div_zero;
        if (w_div_zero) begin
          r_quotient  <= '1;
          r_remainder <= dividend;
        end
      end else if (r_state == ST_RUN) begin
        r_q   <= w_q_nxt;
        r_r   <= w_r_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_quotient  <= w_q_nxt;
          r_remainder <= w_r_nxt[N-1:0];
        end
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule : seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division.
REQ-005 The block SHALL have port stop, input, 1, a synchronous abort.
REQ-006 The block SHALL have port dividend, input, N, the unsigned dividend, sampled at an accepted start.
REQ-007 The block SHALL have port divisor, input, N, the unsigned divisor, sampled at an accepted start.
REQ-008 The block SHALL have port quotient, output, N, the registered result.
REQ-009 The block SHALL have port remainder, output, N, the registered result.
REQ-010 The block SHALL have port busy, output, 1, high while in RUN.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when results become valid.
REQ-012 The block SHALL have port div_by_zero, output, 1, high with done when divisor was 0; held until the next accepted start.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE, encoded in a 2-bit state register.
REQ-014 IDLE or DONE with start=1 and stop=0 at an edge (edge k) SHALL latch dividend into the Q register, clear the (N+1)-bit partial remainder R, latch divisor into D, clear the iteration counter, clear div_by_zero and go to RUN.
- Exception: if divisor=0, the FSM SHALL go straight to DONE.
- In that case quotient SHALL be all ones, remainder SHALL equal dividend, and div_by_zero SHALL be 1.
REQ-015 Each RUN edge SHALL perform one restoring step:
- T = {R[N-1:0], Q[N-1]}.
- If T >= {1'b0, D}: R = T - D and Q = {Q[N-2:0], 1}.
- Otherwise: R = T and Q = {Q[N-2:0], 0}.
REQ-016 The iteration counter SHALL be $clog2(N+1) bits and increment once per RUN edge.
- The Nth step occurs at edge k+N.
- At edge k+N the FSM SHALL enter DONE and load quotient=Q and remainder=R[N-1:0].
REQ-017 done SHALL be 1 exactly during the DONE cycle, i.e. N cycles after the start edge for a nonzero divisor and 1 cycle after it for a zero divisor.
REQ-018 DONE SHALL go to IDLE at the next edge unless a new start is accepted there per REQ-014.
REQ-019 start during RUN SHALL be ignored, and the operands SHALL NOT be re-sampled.
REQ-020 quotient and remainder SHALL hold their last values in IDLE, in DONE and during a following RUN, until the next completion.
REQ-021 stop=1 at any edge SHALL force IDLE, clear busy and done, and leave quotient, remainder and div_by_zero unchanged; stop has priority over start.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every nonzero divisor, including dividend < divisor (quotient 0) and dividend = 0.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for a clk edge, force:
- state to IDLE;
- quotient, remainder, R, Q, D and the counter to 0;
- busy, done and div_by_zero to 0.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation; after release the block SHALL accept a start on the first edge.

Structure
REQ-025 The state encodings (IDLE=0, RUN=1, DONE=2) SHALL reside in the shared package/include seq_div_pkg, shared with the multiplier family.
REQ-026 The default width constant SHALL also reside in seq_div_pkg.
REQ-027 The single restoring step SHALL be a combinational sub-module div_step (inputs R, Q, D; outputs next R and next Q), instantiated once.

Verification
REQ-028 N=8: start with 200/7 -> done pulses exactly 8 cycles after the start edge, quotient=28, remainder=4, div_by_zero=0, and busy high for 8 cycles.
REQ-029 255/0 -> done 1 cycle after start, quotient=255, remainder=255, div_by_zero=1, busy never high.
REQ-030 Boundaries:
- 5/9 -> quotient=0, remainder=5.
- 0/3 -> quotient=0, remainder=0.
- 255/1 -> quotient=255, remainder=0.
- 255/255 -> quotient=1, remainder=0.
REQ-031 Start 100/3, pulse start with 50/5 at RUN cycle 3 -> the second start is ignored and the result is quotient=33, remainder=1.
- Then start 50/5 in the DONE cycle -> it is accepted, giving quotient=10, remainder=0.
REQ-032 Aborts during RUN of 200/7:
- stop at cycle 4 -> IDLE next edge, no done, previous results retained.
- rst at cycle 4 -> all outputs 0 immediately.
REQ-033 Random self-check: 10,000 random operand pairs checked against REQ-022, with done latency per REQ-017.
